// File: rtl/data_mem_pkg.sv
// Shared definitions for the data-memory responder.
// Contents: FSM state encoding, word/lane geometry, wait-state limit and the
// derived wait-counter width.
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dm_state_t;

    localparam int WORD_W     = 32;
    localparam int BYTE_LANES = 4;
    localparam int MAX_WAIT   = 15;
    localparam int CNT_W      = $clog2(MAX_WAIT + 1);

endpackage : data_mem_pkg

// File: rtl/dm_word_array.sv
// Word storage behind the data-memory responder.
// Ports:
//   clk_i    - clock, all updates on the rising edge
//   rst_i    - async active-high reset; clears only the read-data register
//   we_i     - write enable (one-cycle pulse from the responder FSM)
//   re_i     - read enable, captures the addressed word into rdata_o
//   clr_i    - clears rdata_o (store or error response)
//   addr_i   - word index
//   wdata_i  - write data
//   wmask_i  - byte-lane write mask, lane i = bits 8i+7:8i
//   rdata_o  - registered read data
// Array contents are never reset.
module dm_word_array
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic                  clr_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [WORD_W-1:0]     wdata_i,
    input  logic [BYTE_LANES-1:0] wmask_i,
    output logic [WORD_W-1:0]     rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < BYTE_LANES; i++) begin
                if (wmask_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    // The read register doubles as the response data register, so it is
    // the one piece of this block that reset clears.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end else if (clr_i) begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule : dm_word_array

// File: rtl/data_mem_responder.sv
// Memory-side responder for the RV32 core's load/store port.
// Accepts one word request over req_valid/req_ready, waits WAIT_CYCLES
// cycles, performs the access on the word array and presents the result
// over rsp_valid/rsp_ready until consumed.
// Ports:
//   clk, reset (async, active-high)
//   req_valid/req_ready, req_we, req_addr (byte address), req_wdata,
//   req_wstrb (only when DATA_MEM_BYTE_STROBE_EN is defined)
//   rsp_valid/rsp_ready, rsp_rdata (0 for stores and errors), rsp_err
// Build option: DATA_MEM_BYTE_STROBE_EN adds req_wstrb and per-lane stores;
// without it every successful store writes the full word.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [WORD_W-1:0]     req_addr,
    input  logic [WORD_W-1:0]     req_wdata,
`ifdef DATA_MEM_BYTE_STROBE_EN
    input  logic [BYTE_LANES-1:0] req_wstrb,
`endif
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WORD_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);
    localparam logic [WORD_W-3:0] DEPTH_LIMIT = (WORD_W-2)'(DEPTH_WORDS);

    dm_state_t             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  rsp_err_q;

    // Latched request; data-only, so no reset.
    logic                  we_q;
    logic [WORD_W-1:0]     addr_q;
    logic [WORD_W-1:0]     wdata_q;
    logic [BYTE_LANES-1:0] wstrb_q;

    logic                  accept;
    logic                  acc_fire;
    logic                  acc_we;
    logic [WORD_W-1:0]     acc_addr;
    logic [WORD_W-1:0]     acc_wdata;
    logic [BYTE_LANES-1:0] acc_wstrb;
    logic [BYTE_LANES-1:0] req_strb;
    logic                  acc_err;

`ifdef DATA_MEM_BYTE_STROBE_EN
    assign req_strb = req_wstrb;
`else
    assign req_strb = '1;
`endif

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign accept    = req_ready && req_valid;

    // ---------------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d  = RESP;
                        acc_fire = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d  = RESP;
                    acc_fire = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_strb;
        end
    end

    // ---------------------------------------------------------------------
    // Access on the RESP-entry edge. With zero wait states that edge is the
    // accept edge itself, so the live request is used instead of the latch.
    // ---------------------------------------------------------------------
    always_comb begin
        if (state_q == IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_wstrb = req_strb;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_wstrb = wstrb_q;
        end
    end

    // The full upper address is range-checked so high addresses never alias
    // onto low words.
    assign acc_err = (acc_addr[1:0] != 2'b00) ||
                     (acc_addr[WORD_W-1:2] >= DEPTH_LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_err_q <= 1'b0;
        end else if (acc_fire) begin
            rsp_err_q <= acc_err;
        end
    end

    assign rsp_err = rsp_err_q;

    dm_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_array (
        .clk_i   (clk),
        .rst_i   (reset),
        .we_i    (acc_fire && acc_we && !acc_err),
        .re_i    (acc_fire && !acc_we && !acc_err),
        .clr_i   (acc_fire && (acc_we || acc_err)),
        .addr_i  (acc_addr[2 +: ADDR_W]),
        .wdata_i (acc_wdata),
        .wmask_i (acc_wstrb),
        .rdata_o (rsp_rdata)
    );

endmodule : data_mem_responder

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder. Instance 0 uses one wait state,
// instance 1 uses three; both use the default 64-word depth.
module tb_data_mem_responder;

    logic        clk;
    logic        reset     [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
`ifdef DATA_MEM_BYTE_STROBE_EN
    logic [3:0]  req_wstrb [2];
    logic [3:0]  wstrb_sel;
`endif
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int n_checks = 0;
    int n_errors = 0;

    data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(1)) dut0 (
        .clk       (clk),
        .reset     (reset[0]),
        .req_valid (req_valid[0]),
        .req_ready (req_ready[0]),
        .req_we    (req_we[0]),
        .req_addr  (req_addr[0]),
        .req_wdata (req_wdata[0]),
`ifdef DATA_MEM_BYTE_STROBE_EN
        .req_wstrb (req_wstrb[0]),
`endif
        .rsp_valid (rsp_valid[0]),
        .rsp_ready (rsp_ready[0]),
        .rsp_rdata (rsp_rdata[0]),
        .rsp_err   (rsp_err[0])
    );

    data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(3)) dut1 (
        .clk       (clk),
        .reset     (reset[1]),
        .req_valid (req_valid[1]),
        .req_ready (req_ready[1]),
        .req_we    (req_we[1]),
        .req_addr  (req_addr[1]),
        .req_wdata (req_wdata[1]),
`ifdef DATA_MEM_BYTE_STROBE_EN
        .req_wstrb (req_wstrb[1]),
`endif
        .rsp_valid (rsp_valid[1]),
        .rsp_ready (rsp_ready[1]),
        .rsp_rdata (rsp_rdata[1]),
        .rsp_err   (rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one request, let it be accepted, scramble the request inputs
    // and wait (bounded) for rsp_valid. lat counts cycles from accept.
    task automatic issue(input int k, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat);
        @(negedge clk);
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
`ifdef DATA_MEM_BYTE_STROBE_EN
        req_wstrb[k] = wstrb_sel;
`endif
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
        req_we[k]    = ~we;
        req_addr[k]  = addr ^ 32'h0000_0044;
        req_wdata[k] = ~wdata;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (rsp_valid[k]) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) check("rsp_valid_timeout", 32'(rsp_valid[k]), 32'd1);
    endtask

    // Full transaction with rsp_ready held high.
    task automatic do_req(input int k, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rd,
                          output logic er, output int lat);
        issue(k, we, addr, wdata, lat);
        rd = rsp_rdata[k];
        er = rsp_err[k];
        @(posedge clk);
        #1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;

    initial begin
        for (int k = 0; k < 2; k++) begin
            reset[k]     = 1'b1;
            req_valid[k] = 1'b0;
            req_we[k]    = 1'b0;
            req_addr[k]  = '0;
            req_wdata[k] = '0;
            rsp_ready[k] = 1'b1;
`ifdef DATA_MEM_BYTE_STROBE_EN
            req_wstrb[k] = 4'hF;
`endif
        end
`ifdef DATA_MEM_BYTE_STROBE_EN
        wstrb_sel = 4'hF;
`endif
        repeat (2) @(negedge clk);
        check("reset_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("reset_req_ready", 32'(req_ready[0]), 32'd1);
        check("reset_rsp_err",   32'(rsp_err[0]),   32'd0);
        check("reset_rsp_rdata", rsp_rdata[0],      32'd0);
        reset[0] = 1'b0;
        reset[1] = 1'b0;

        // Store then load, one wait state
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
        check("st10_lat",   32'(lat), 32'd2);
        check("st10_err",   32'(er),  32'd0);
        check("st10_rdata", rd,       32'd0);
        do_req(0, 1'b0, 32'h10, 32'h0, rd, er, lat);
        check("ld10_lat",   32'(lat), 32'd2);
        check("ld10_err",   32'(er),  32'd0);
        check("ld10_rdata", rd,       32'hDEADBEEF);

        do_req(0, 1'b1, 32'h0, 32'h0BADF00D, rd, er, lat);
        do_req(0, 1'b1, 32'hFC, 32'hA5A5_0FF0, rd, er, lat);
        check("stFC_err", 32'(er), 32'd0);
        do_req(0, 1'b0, 32'hFC, 32'h0, rd, er, lat);
        check("ldFC_rdata", rd, 32'hA5A5_0FF0);
        do_req(0, 1'b0, 32'h0, 32'h0, rd, er, lat);
        check("ld00_rdata", rd, 32'h0BADF00D);

        // Error cases
        do_req(0, 1'b0, 32'h13, 32'h0, rd, er, lat);
        check("ld13_err",   32'(er), 32'd1);
        check("ld13_rdata", rd,      32'd0);
        do_req(0, 1'b1, 32'h100, 32'hCAFEBABE, rd, er, lat);
        check("st100_err",   32'(er), 32'd1);
        check("st100_rdata", rd,      32'd0);
        do_req(0, 1'b0, 32'h0, 32'h0, rd, er, lat);
        check("ld00_after_oor", rd, 32'h0BADF00D);
        do_req(0, 1'b1, 32'h8000_0010, 32'h5555_AAAA, rd, er, lat);
        check("st_hi_err", 32'(er), 32'd1);
        do_req(0, 1'b0, 32'h10, 32'h0, rd, er, lat);
        check("ld10_after_hi", rd, 32'hDEADBEEF);

        // Backpressure: response held, a competing request must stall
        rsp_ready[0] = 1'b0;
        issue(0, 1'b0, 32'h10, 32'h0, lat);
        check("bp_lat", 32'(lat), 32'd2);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h10;
        req_wdata[0] = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid[0]), 32'd1);
            check("bp_rsp_rdata", rsp_rdata[0],      32'hDEADBEEF);
            check("bp_req_ready", 32'(req_ready[0]), 32'd0);
        end
        rsp_ready[0] = 1'b1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("bp_release_valid", 32'(rsp_valid[0]), 32'd0);
        check("bp_release_ready", 32'(req_ready[0]), 32'd1);
        do_req(0, 1'b0, 32'h10, 32'h0, rd, er, lat);
        check("bp_no_store", rd, 32'hDEADBEEF);

        // Asynchronous reset between clock edges while a response is held
        rsp_ready[0] = 1'b0;
        issue(0, 1'b0, 32'h10, 32'h0, lat);
        check("ar_pre_valid", 32'(rsp_valid[0]), 32'd1);
        #2;
        reset[0] = 1'b1;
        #1;
        check("ar_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("ar_rsp_err",   32'(rsp_err[0]),   32'd0);
        check("ar_rsp_rdata", rsp_rdata[0],      32'd0);
        check("ar_req_ready", 32'(req_ready[0]), 32'd1);
        @(negedge clk);
        reset[0]     = 1'b0;
        rsp_ready[0] = 1'b1;
        do_req(0, 1'b0, 32'h10, 32'h0, rd, er, lat);
        check("ar_mem_kept", rd, 32'hDEADBEEF);

        // Three wait states; reset in the second wait cycle abandons a store
        do_req(1, 1'b1, 32'h20, 32'h1111_1111, rd, er, lat);
        check("w3_st_lat", 32'(lat), 32'd4);
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_addr[1]  = 32'h20;
        req_wdata[1] = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(posedge clk);
        #2;
        reset[1] = 1'b1;
        @(negedge clk);
        check("rw_rsp_valid", 32'(rsp_valid[1]), 32'd0);
        check("rw_req_ready", 32'(req_ready[1]), 32'd1);
        reset[1] = 1'b0;
        do_req(1, 1'b0, 32'h20, 32'h0, rd, er, lat);
        check("rw_ld_lat",   32'(lat), 32'd4);
        check("rw_ld_rdata", rd,       32'h1111_1111);

`ifdef DATA_MEM_BYTE_STROBE_EN
        wstrb_sel = 4'hF;
        do_req(0, 1'b1, 32'h30, 32'h11223344, rd, er, lat);
        wstrb_sel = 4'b0101;
        do_req(0, 1'b1, 32'h30, 32'hAABBCCDD, rd, er, lat);
        check("strb5_err", 32'(er), 32'd0);
        do_req(0, 1'b0, 32'h30, 32'h0, rd, er, lat);
        check("strb5_rdata", rd, 32'h11BB33DD);
        wstrb_sel = 4'b0000;
        do_req(0, 1'b1, 32'h30, 32'hFFFFFFFF, rd, er, lat);
        check("strb0_err", 32'(er), 32'd0);
        wstrb_sel = 4'hF;
        do_req(0, 1'b0, 32'h30, 32'h0, rd, er, lat);
        check("strb0_rdata", rd, 32'h11BB33DD);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_data_mem_responder

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the single-cycle RV32 core's load/store port. It accepts one word request at a time over a valid/ready handshake, inserts a configurable number of wait states, then performs the read or write on an internal word array. It returns data and an error flag over a second valid/ready handshake. It sits between the core's data-access interface (`ALUResult` as address, `WriteData`, `ReadData`) and the backing store.

## Interface
- `DEPTH_WORDS`, default 64: number of 32-bit words; power of two, ≥ 2.
- `WAIT_CYCLES`, default 1: wait states between accept and access; 0 to 15.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears FSM and all output registers.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data.
- `req_wstrb` in 4: byte-lane enables. Present only with `DATA_MEM_BYTE_STROBE_EN`.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: requester consumes the response.
- `rsp_rdata` out 32: load data. 0 for stores and errors.
- `rsp_err` out 1: misaligned or out-of-range access.

## Operation
- FSM states are IDLE, WAIT, RESP. Reset state is IDLE.
- Values held in reset:
  - `req_ready` = 1 (combinational from the IDLE state).
  - `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0.
  - Wait counter = 0.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid` & `req_ready`, latch `we`, `addr`, `wdata` (and `wstrb`).
  - If `WAIT_CYCLES` = 0, go to RESP. Otherwise load counter = `WAIT_CYCLES` − 1 and go to WAIT.
- WAIT:
  - `req_ready` = 0.
  - Decrement the counter each cycle. When it reaches 0, go to RESP.
- Access happens on the entry edge into RESP:
  - Error check: `rsp_err` = (`addr[1:0]` != 0) | (`addr[31:2]` ≥ `DEPTH_WORDS`).
  - Error: the array is not modified and `rsp_rdata` = 0.
  - Store without error: write `mem[addr[2 +: log2(DEPTH_WORDS)]]`; `rsp_rdata` = 0.
  - Load without error: `rsp_rdata` = the addressed word, registered.
- RESP:
  - `rsp_valid` = 1.
  - `rsp_rdata` and `rsp_err` are held stable until `rsp_valid` & `rsp_ready`, then go to IDLE.
  - `rsp_valid` deasserts on that edge.
- Only one request is outstanding at a time. `req_ready` is low in WAIT and RESP, so new requests stall.
- Request inputs are sampled only at the accept edge. Later changes are ignored.
- Read-after-write: a load accepted after a store's response handshake sees the stored data.
- Array contents are not affected by reset and are undefined after power-up.
- Reset during WAIT: the pending store is abandoned and the array is unchanged.
- Reset during RESP: the response is dropped.

## Timing
- Accept-to-`rsp_valid` latency = `WAIT_CYCLES` + 1 cycles.
- Minimum request period = `WAIT_CYCLES` + 2 cycles, when `rsp_ready` is held at 1.
- `rsp_ready` may be high before `rsp_valid`. The handshake completes on the first edge where both are 1.
- `req_ready` depends only on state, never combinationally on `req_valid`.
- Nothing depends combinationally on `rsp_ready`.

## Configuration
- Macro: `DATA_MEM_BYTE_STROBE_EN`.
- Defined:
  - The `req_wstrb` port exists.
  - A store writes only lanes whose strobe is 1 (lane i = bits 8i+7:8i).
  - `wstrb` = 0 is a legal no-op store with `rsp_err` = 0.
- Undefined:
  - The port is absent.
  - Every non-error store writes all 4 lanes.
- Alignment and range checks are identical in both builds.

## Structure
- Package `data_mem_pkg`:
  - State enum `dm_state_t` {IDLE, WAIT, RESP}.
  - `WORD_W` = 32, `BYTE_LANES` = 4.
  - `MAX_WAIT` = 15.
- Sub-module `dm_word_array`:
  - `DEPTH_WORDS` × 32 storage with synchronous write (optional lane mask) and synchronous registered read.
  - Read and write are both enabled by the top FSM on the RESP-entry edge.

## Test plan
- Reset check: assert `reset` mid-cycle with no clock edge -> `rsp_valid` = 0, `rsp_err` = 0, `rsp_rdata` = 0, `req_ready` = 1 immediately (asynchronous).
- Store then load, `WAIT_CYCLES` = 1:
  - Store `addr` 0x10, data 0xDEADBEEF -> `rsp_valid` 2 cycles after accept, `rsp_err` = 0, `rsp_rdata` = 0.
  - Load 0x10 -> `rsp_rdata` = 0xDEADBEEF.
- Error cases, `DEPTH_WORDS` = 64:
  - Load 0x13 (misaligned) -> `rsp_err` = 1, `rsp_rdata` = 0.
  - Store 0x100 (out of range) -> `rsp_err` = 1, and a load of 0x0 still returns its prior value.
- Backpressure:
  - Hold `rsp_ready` = 0 for 5 cycles -> `rsp_valid`/`rsp_rdata` stable, `req_ready` = 0, a new `req_valid` is not accepted.
  - Release `rsp_ready` -> IDLE next cycle.
- Reset during WAIT (`WAIT_CYCLES` = 3):
  - Store 0x20 = 0x12345678, assert `reset` in the 2nd wait cycle.
  - A later load of 0x20 returns the old value.
- With `DATA_MEM_BYTE_STROBE_EN`:
  - Store 0xAABBCCDD, `wstrb` = 0b0101, over 0x11223344 -> load returns 0x11BB33DD.
  - `wstrb` = 0 -> word unchanged, `rsp_err` = 0.
